wb_arbiter: RTL
===============

# wb_arbiter

Write-back arbiter that owns the single write port of the register file. It merges single-cycle ALU results and handshaked load returns from the memory unit. ALU results are buffered in a small FIFO while a load holds the port. Each cycle it issues at most one registered write (reg_write/rd/write_data) and reports pending-write hazards for the decode stage's rs1/rs2.

## Interface
- ALU_FIFO_DEPTH, 4, entries in ALU result FIFO (power of two, >=2)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU result present
- alu_rd  input  5  ALU destination register
- alu_data  input  32  ALU result
- alu_ready  output  1  FIFO can accept (= !full)
- mem_valid  input  1  load return present; held with rd/data stable until accepted
- mem_rd  input  5  load destination register
- mem_data  input  32  load data
- mem_ready  output  1  load granted this cycle
- rs1, rs2  input  5 each  decode-stage source addresses
- hazard1, hazard2  output  1 each  uncommitted write pending to rs1 / rs2
- reg_write  output  1  register-file write enable (registered)
- rd  output  5  register-file write address (registered)
- write_data  output  32  register-file write data (registered)
- busy  output  1  FIFO non-empty or reg_write high

## Operation
- ALU path: alu_valid && alu_ready at edge pushes {alu_rd, alu_data}. The entry is eligible for grant from the next cycle. No bypass around the FIFO.
- Candidates each cycle: A = FIFO non-empty (head), M = mem_valid.
- Grant rules:
  - Only A: grant A.
  - Only M: grant M.
  - Both: grant the source not granted last; last_grant updates only on a grant.
- mem_ready = grant-to-M, combinational from current state and mem_valid. An ALU grant pops the FIFO at the edge.
- FIFO status:
  - Push and pop in the same cycle: count unchanged.
  - Push while full is impossible (alu_ready=0); alu_valid is ignored then.
  - Pointers wrap modulo ALU_FIFO_DEPTH.
- Output register, on each edge:
  - If a grant occurred: rd/write_data load the granted rd/data; reg_write = (granted rd != 0).
  - Otherwise reg_write = 0; rd/write_data hold.
  - rd==0 writes are consumed and retired silently.
- hazardN = (rsN != 0) && (any valid FIFO entry has rd == rsN, or (reg_write && rd == rsN)). Purely combinational; no look-ahead on mem_valid.
- Reset (reset low, async):
  - FIFO pointers and count cleared.
  - last_grant = ALU, so the first tie goes to mem.
  - reg_write=0, rd=0, write_data=0.
  - alu_ready, mem_ready, hazard1/2 and busy forced 0 while reset is low.
- Reset mid-operation discards all buffered ALU results and any in-flight output write. alu_ready returns 1 in the first cycle after release.

## Timing
- Load: accepted at edge T → reg_write high in cycle T..T+1 → register file commits at edge T+1.
- ALU, port idle: pushed at edge T → granted in cycle T..T+1 → reg_write high after edge T+1 → committed at edge T+2.
- Throughput: one write per cycle sustained. Under continuous contention, A and M alternate 1:1.
- Worst-case ALU wait behind loads: 1 grant per 2 cycles. The FIFO fills only if ALU pushes every cycle during contention.
- Output register fields change only on the clock edge (and on reset).
- Hazard flags deassert in the cycle after the write commits.

## Test plan
- Reset release, idle: reg_write=0, rd=0, write_data=0, alu_ready=1, busy=0. Push alu_rd=5, data=0x0000000B → reg_write=1, rd=5, write_data=0xB exactly one cycle, two edges after push.
- Simultaneous after reset: FIFO holds {3,0x11}; mem_valid with {7,0x22} → mem granted first (mem_ready=1 that cycle), ALU next cycle. Output sequence: rd=7 then rd=3, consecutive cycles.
- Continuous contention: ALU pushes each cycle, mem_valid held high for 8 cycles → grants alternate M,A,M,A…. The FIFO saturates at 4; alu_ready drops to 0 and pushes stall without data loss or reordering.
- x0 suppression: mem {0,0xDEADBEEF} → mem_ready=1, reg_write stays 0. Then ALU {0,0x1} → reg_write stays 0; FIFO empties; busy=0.
- Hazard: FIFO holds rd=4, rs1=4, rs2=0 → hazard1=1, hazard2=0. hazard1 stays 1 through the reg_write cycle and drops after commit. rs1=4 with rd=0 entries only → hazard1=0.
- Async reset mid-stream: FIFO with 3 entries and reg_write=1, then reset low mid-cycle → reg_write, busy and readies 0 immediately. After release, no stale write appears and the FIFO is empty.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back arbiter's bus signals: ALU result push, load return
// handshake, decode hazard query and the registered register-file write port.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard1;
  logic        hazard2;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        busy;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs1, rs2,
    input  alu_ready, mem_ready, hazard1, hazard2, reg_write, rd, write_data, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs1, rs2,
    output alu_ready, mem_ready, hazard1, hazard2, reg_write, rd, write_data, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers ALU results in a FIFO, alternates with load returns
// on contention, and drives one registered register-file write per cycle.
module wb_arbiter #(
  parameter int ALU_FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(ALU_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(ALU_FIFO_DEPTH);

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_e;

  logic [4:0]    r_fifo_rd   [ALU_FIFO_DEPTH];
  logic [31:0]   r_fifo_data [ALU_FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  grant_e        r_last;
  grant_e        w_last_nxt;
  logic          r_reg_write;
  logic [4:0]    r_rd;
  logic [31:0]   r_write_data;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_grant_mem;
  logic          w_grant_any;
  logic [4:0]    w_gnt_rd;
  logic [31:0]   w_gnt_data;
  logic          w_hz1;
  logic          w_hz2;

  // FIFO status and round-robin grant between FIFO head and load return
  always_comb begin
    w_full      = (r_count == FULL_CNT);
    w_empty     = (r_count == CW'(0));
    w_push      = bus.alu_valid && !w_full;
    w_grant_mem = 1'b0;
    w_pop       = 1'b0;
    w_gnt_rd    = r_fifo_rd[r_rd_ptr];
    w_gnt_data  = r_fifo_data[r_rd_ptr];
    w_last_nxt  = r_last;
    if (bus.mem_valid && (w_empty || (r_last == GRANT_ALU))) begin
      w_grant_mem = 1'b1;
      w_gnt_rd    = bus.mem_rd;
      w_gnt_data  = bus.mem_data;
      w_last_nxt  = GRANT_MEM;
    end else if (!w_empty) begin
      w_pop      = 1'b1;
      w_last_nxt = GRANT_ALU;
    end else begin
      w_last_nxt = r_last;
    end
    w_grant_any = w_grant_mem || w_pop;
  end

  // Hazard scan: live FIFO entries are those within count of the read pointer
  always_comb begin
    w_hz1 = 1'b0;
    w_hz2 = 1'b0;
    for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
      w_hz1 = w_hz1 | (({1'b0, PW'(PW'(i) - r_rd_ptr)} < r_count) && (r_fifo_rd[i] == bus.rs1));
      w_hz2 = w_hz2 | (({1'b0, PW'(PW'(i) - r_rd_ptr)} < r_count) && (r_fifo_rd[i] == bus.rs2));
    end
    w_hz1 = (w_hz1 | (r_reg_write && (r_rd == bus.rs1))) && (bus.rs1 != 5'd0);
    w_hz2 = (w_hz2 | (r_reg_write && (r_rd == bus.rs2))) && (bus.rs2 != 5'd0);
  end

  // FIFO storage; entries beyond count are never observed, so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= bus.alu_rd;
      r_fifo_data[r_wr_ptr] <= bus.alu_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Last-grant memory and the registered write port; x0 writes retire silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last       <= GRANT_ALU;
      r_reg_write  <= 1'b0;
      r_rd         <= 5'd0;
      r_write_data <= 32'd0;
    end else begin
      r_last <= w_last_nxt;
      if (w_grant_any) begin
        r_reg_write  <= (w_gnt_rd != 5'd0);
        r_rd         <= w_gnt_rd;
        r_write_data <= w_gnt_data;
      end else begin
        r_reg_write  <= 1'b0;
      end
    end
  end

  assign bus.alu_ready  = reset && !w_full;
  assign bus.mem_ready  = reset && w_grant_mem;
  assign bus.hazard1    = reset && w_hz1;
  assign bus.hazard2    = reset && w_hz2;
  assign bus.busy       = reset && (!w_empty || r_reg_write);
  assign bus.reg_write  = r_reg_write;
  assign bus.rd         = r_rd;
  assign bus.write_data = r_write_data;
endmodule
